// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter slice.
// Holds the default geometry of the shared SRAM and requester count, and a
// one-hot to binary index helper used by the round-robin arbiters.
package sram_port_arbiter_pkg;

  localparam int NUM_REQ_DEF    = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  // Upper bound on requesters; the helper below is sized for it.
  localparam int MAX_REQ = 8;

  // Converts a one-hot (or all-zero) vector into the index of its set bit.
  // OR-accumulation keeps it a small mux tree; an all-zero input yields 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter.
// Bundles the per-requester write and read handshakes plus the read response.
//   wr_valid/wr_addr/wr_data/wr_ready : write request channel (packed per requester)
//   rd_valid/rd_addr/rd_ready         : read request channel (packed per requester)
//   rd_resp_valid/rd_resp_data        : one-hot read response and shared data
// Modports: master = requester side, slave = arbiter side.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic [NUM_REQ-1:0]            wr_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]            wr_ready;

  logic [NUM_REQ-1:0]            rd_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]            rd_ready;

  logic [NUM_REQ-1:0]            rd_resp_valid;
  logic [DATA_WIDTH-1:0]         rd_resp_data;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready, rd_resp_valid, rd_resp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready, rd_resp_valid, rd_resp_data
  );

endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : per-requester request vector
//   hs         : handshake strobe; advances the pointer past the granted requester
//   gnt        : one-hot grant (combinational, zero while in reset)
//   gnt_idx    : binary index of the granted requester
module rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 hs,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr;

  // Search from the pointer upward, wrapping, and grant the first requester
  // found. Grants are suppressed during reset so no SRAM access can leak out.
  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        idx = int'(ptr) + i;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  assign gnt_idx = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));

  // After a handshake the requester just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1R/1W SRAM between NUM_REQ requesters.
// Write and read ports are arbitrated independently with round-robin
// priority; the granted requester's slices drive the SRAM, and read data is
// returned with a one-hot response valid one cycle after the handshake.
//   clk, rst_n   : clock and asynchronous active-low reset
//   bus          : requester handshakes and read response (slave modport)
//   sram_csen    : chip select, high when either port accesses
//   sram_wr_*    : write enable, address and data
//   sram_rd_*    : read enable and address; sram_rd_data returns a cycle later
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_arbiter_if.slave    bus,
  output logic                  sram_csen,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic               wr_hs, rd_hs;

  assign wr_hs = |(bus.wr_valid & wr_gnt);
  assign rd_hs = |(bus.rd_valid & rd_gnt);

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.wr_valid),
    .hs      (wr_hs),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.rd_valid),
    .hs      (rd_hs),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  assign bus.wr_ready = wr_gnt;
  assign bus.rd_ready = rd_gnt;

  assign sram_wr_en = wr_hs;
  assign sram_rd_en = rd_hs;
  assign sram_csen  = wr_hs | rd_hs;

  // Steer the granted requester's slices onto the SRAM; idle ports drive 0.
  always_comb begin
    sram_wr_addr = '0;
    sram_wr_data = '0;
    sram_rd_addr = '0;
    if (wr_hs) begin
      sram_wr_addr = bus.wr_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      sram_wr_data = bus.wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (rd_hs) begin
      sram_rd_addr = bus.rd_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The SRAM returns data one cycle after the read enable, so the grant is
  // delayed by one register to tag that data with its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_resp_valid <= '0;
    end else begin
      bus.rd_resp_valid <= rd_gnt & bus.rd_valid;
    end
  end

  // Data is masked outside a response so the bus reads 0 when idle or in reset.
  assign bus.rd_resp_data = (|bus.rd_resp_valid) ? sram_rd_data : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural 1R/1W SRAM.
// Directed stimulus pushes expected read responses into a queue; a monitor
// on the falling edge pops and compares whenever a response is presented.
module tb_sram_port_arbiter;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int AW = 8;

  typedef struct packed {
    logic [NR-1:0] valid;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } resp_t;

  logic          clk;
  logic          rst_n;
  logic          load_mem;
  logic          sram_csen, sram_wr_en, sram_rd_en;
  logic [AW-1:0] sram_wr_addr, sram_rd_addr;
  logic [DW-1:0] sram_wr_data, sram_rd_data;
  logic [DW-1:0] mem [256];

  int    check_count = 0;
  int    pass_count  = 0;
  int    cyc         = 0;
  resp_t exp_q[$];

  sram_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sram_csen    (sram_csen),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Registered-read SRAM; a same-edge read sees the pre-write contents.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i < 8) ? (8'hC0 | 8'(i)) : 8'h00;
    end else begin
      if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
      if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic apply_stimulus(input logic [NR-1:0] wv, input logic [NR*AW-1:0] wa,
                                input logic [NR*DW-1:0] wd, input logic [NR-1:0] rv,
                                input logic [NR*AW-1:0] ra);
    @(posedge clk);
    #1;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
  endtask

  task automatic expect_resp(input logic [NR-1:0] v, input logic [DW-1:0] d);
    resp_t e;
    e.valid = v;
    e.data  = d;
    e.due   = 32'(cyc + 1);
    exp_q.push_back(e);
  endtask

  // Response monitor: every presented response must match the queue head
  // and arrive exactly one cycle after its handshake.
  always @(negedge clk) begin
    resp_t e;
    if (bus.rd_resp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_resp: got valid %0b data %0h, expected none",
                 bus.rd_resp_valid, bus.rd_resp_data);
      end else begin
        e = exp_q.pop_front();
        check_output("resp_valid", 32'(bus.rd_resp_valid), 32'(e.valid));
        check_output("resp_data", 32'(bus.rd_resp_data), 32'(e.data));
        check_output("resp_cycle", 32'(cyc), e.due);
      end
    end
  end

  logic [DW-1:0] rot_data [NR];

  initial begin
    rot_data[0] = 8'hA5;
    rot_data[1] = 8'h3C;
    rot_data[2] = 8'h52;

    rst_n        = 1'b0;
    load_mem     = 1'b1;
    bus.wr_valid = 3'b111;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 3'b111;
    bus.rd_addr  = '0;
    @(posedge clk);
    #1 load_mem = 1'b0;

    // Reset with every valid high: nothing may be granted.
    @(negedge clk);
    check_output("rst_wr_ready", 32'(bus.wr_ready), 32'h0);
    check_output("rst_rd_ready", 32'(bus.rd_ready), 32'h0);
    check_output("rst_csen", 32'(sram_csen), 32'h0);
    check_output("rst_wr_en", 32'(sram_wr_en), 32'h0);
    check_output("rst_rd_en", 32'(sram_rd_en), 32'h0);
    check_output("rst_resp_valid", 32'(bus.rd_resp_valid), 32'h0);

    @(posedge clk);
    #1;
    bus.wr_valid = '0;
    bus.rd_valid = '0;
    rst_n        = 1'b1;

    // Three writers contending: grants rotate 001, 010, 100.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(3'b111, {8'hF2, 8'hF1, 8'hF0}, {8'h52, 8'h51, 8'h50}, 3'b000, '0);
      @(negedge clk);
      check_output("wr_rotate_gnt", 32'(bus.wr_ready), 32'(3'b001 << i));
      check_output("wr_rotate_addr", 32'(sram_wr_addr), 32'(8'hF0 + 8'(i)));
    end

    // Requester 1 writes 0x10 <= 0xA5, then requester 2 reads it back.
    apply_stimulus(3'b010, {8'h00, 8'h10, 8'h00}, {8'h00, 8'hA5, 8'h00}, 3'b000, '0);
    @(negedge clk);
    check_output("wr1_ready", 32'(bus.wr_ready), 32'(3'b010));
    check_output("wr1_en", 32'(sram_wr_en), 32'h1);
    check_output("wr1_csen", 32'(sram_csen), 32'h1);
    check_output("wr1_addr", 32'(sram_wr_addr), 32'h10);
    check_output("wr1_data", 32'(sram_wr_data), 32'hA5);

    apply_stimulus(3'b000, '0, '0, 3'b100, {8'h10, 8'h00, 8'h00});
    expect_resp(3'b100, 8'hA5);
    @(negedge clk);
    check_output("rd2_ready", 32'(bus.rd_ready), 32'(3'b100));
    check_output("rd2_en", 32'(sram_rd_en), 32'h1);
    check_output("rd2_addr", 32'(sram_rd_addr), 32'h10);
    check_output("rd2_wr_idle", 32'(sram_wr_en), 32'h0);

    // Same-cycle write and read to 0x20: read sees the old value.
    apply_stimulus(3'b001, {8'h00, 8'h00, 8'h20}, {8'h00, 8'h00, 8'h3C},
                   3'b010, {8'h00, 8'h20, 8'h00});
    expect_resp(3'b010, 8'h00);
    @(negedge clk);
    check_output("rbw_wr_ready", 32'(bus.wr_ready), 32'(3'b001));
    check_output("rbw_rd_ready", 32'(bus.rd_ready), 32'(3'b010));
    check_output("rbw_csen", 32'(sram_csen), 32'h1);

    apply_stimulus(3'b000, '0, '0, 3'b010, {8'h00, 8'h20, 8'h00});
    expect_resp(3'b010, 8'h3C);
    @(negedge clk);
    check_output("reread_ready", 32'(bus.rd_ready), 32'(3'b010));

    // Requester 2 read moves the read pointer back to requester 0.
    apply_stimulus(3'b000, '0, '0, 3'b100, {8'h10, 8'h00, 8'h00});
    expect_resp(3'b100, 8'hA5);
    @(negedge clk);
    check_output("rd_realign_ready", 32'(bus.rd_ready), 32'(3'b100));

    // All three readers for nine cycles: fair rotation.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(3'b000, '0, '0, 3'b111, {8'hF2, 8'h20, 8'h10});
      expect_resp(3'(3'b001 << (i % 3)), rot_data[i % 3]);
      @(negedge clk);
      check_output("rd_rotate_gnt", 32'(bus.rd_ready), 32'(3'b001 << (i % 3)));
    end

    // Requester 0 streaming reads 0..7 with no bubbles.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(3'b000, '0, '0, 3'b001, {8'h00, 8'h00, 8'(i)});
      expect_resp(3'b001, 8'hC0 | 8'(i));
      @(negedge clk);
      check_output("stream_ready", 32'(bus.rd_ready), 32'(3'b001));
    end

    // Reset right after a read handshake drops the response.
    apply_stimulus(3'b000, '0, '0, 3'b001, {8'h00, 8'h00, 8'h10});
    @(negedge clk);
    check_output("drop_rd_ready", 32'(bus.rd_ready), 32'(3'b001));
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.rd_valid = '0;
    @(negedge clk);
    check_output("drop_resp_valid", 32'(bus.rd_resp_valid), 32'h0);
    check_output("drop_resp_data", 32'(bus.rd_resp_data), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pointer back at 0: requester 0 beats requester 2.
    apply_stimulus(3'b000, '0, '0, 3'b101, {8'hF2, 8'h00, 8'h10});
    expect_resp(3'b001, 8'hA5);
    @(negedge clk);
    check_output("post_rst_ready", 32'(bus.rd_ready), 32'(3'b001));

    apply_stimulus(3'b000, '0, '0, 3'b000, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
